id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB,
// plus the combinational load-use hazard request to pipeline control.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [3:0]      id_ALUop,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_valid,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [XLEN-1:0] store_data,
  output logic [3:0]      ALUop,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_valid,
  output logic            load_use_stall
);

  // Pipeline entry held between decode and execute.
  logic [XLEN-1:0] rs1_data_p0;
  logic [XLEN-1:0] rs2_data_p0;
  logic [XLEN-1:0] imm_p0;
  logic [4:0]      rs1_p0;
  logic [4:0]      rs2_p0;
  logic [4:0]      rd_p0;
  logic [3:0]      alu_op_p0;
  logic            alu_src_p0;
  logic            reg_write_p0;
  logic            mem_read_p0;
  logic            vld_p0;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Picks the newest in-flight value for a source register. EX/MEM is the
  // younger producer so it wins; register 0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] reg_val,
    input logic [4:0]      ex_dst,
    input logic            ex_wr,
    input logic [XLEN-1:0] ex_val,
    input logic [4:0]      wb_dst,
    input logic            wb_wr,
    input logic [XLEN-1:0] wb_val
  );
    if (rs != 5'd0 && ex_wr && ex_dst == rs)
      return ex_val;
    else if (rs != 5'd0 && wb_wr && wb_dst == rs)
      return wb_val;
    else
      return reg_val;
  endfunction

  // ---- ID -> EX boundary: flush bubbles, stall holds, otherwise capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_data_p0  <= '0;
      rs2_data_p0  <= '0;
      imm_p0       <= '0;
      rs1_p0       <= '0;
      rs2_p0       <= '0;
      rd_p0        <= '0;
      alu_op_p0    <= '0;
      alu_src_p0   <= 1'b0;
      reg_write_p0 <= 1'b0;
      mem_read_p0  <= 1'b0;
      vld_p0       <= 1'b0;
    end else if (flush) begin
      alu_op_p0    <= '0;
      reg_write_p0 <= 1'b0;
      mem_read_p0  <= 1'b0;
      vld_p0       <= 1'b0;
    end else if (!stall) begin
      rs1_data_p0  <= id_rs1_data;
      rs2_data_p0  <= id_rs2_data;
      imm_p0       <= id_imm;
      rs1_p0       <= id_rs1;
      rs2_p0       <= id_rs2;
      rd_p0        <= id_rd;
      alu_op_p0    <= id_ALUop;
      alu_src_p0   <= id_alu_src;
      reg_write_p0 <= id_valid & id_reg_write;
      mem_read_p0  <= id_valid & id_mem_read;
      vld_p0       <= id_valid;
    end
  end

  // ---- EX operand selection: forwarding re-evaluated every cycle ----
  always_comb begin
    fwd_rs1 = fwd_sel(rs1_p0, rs1_data_p0, exmem_rd, exmem_reg_write, exmem_result,
                      memwb_rd, memwb_reg_write, memwb_result);
    fwd_rs2 = fwd_sel(rs2_p0, rs2_data_p0, exmem_rd, exmem_reg_write, exmem_result,
                      memwb_rd, memwb_reg_write, memwb_result);
  end

  assign a          = fwd_rs1;
  assign b          = alu_src_p0 ? imm_p0 : fwd_rs2;
  assign store_data = fwd_rs2;

  assign ALUop        = alu_op_p0;
  assign ex_rd        = rd_p0;
  assign ex_reg_write = reg_write_p0;
  assign ex_mem_read  = mem_read_p0;
  assign ex_valid     = vld_p0;

  // A load in EX whose destination feeds the instruction now in decode
  // cannot be forwarded in time; ask control to hold decode one cycle.
  assign load_use_stall = vld_p0 && mem_read_p0 && (rd_p0 != 5'd0) &&
                          ((rd_p0 == id_rs1) || (rd_p0 == id_rs2)) && id_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural model.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            stall, flush;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [3:0]      id_ALUop;
  logic            id_alu_src, id_reg_write, id_mem_read, id_valid;
  logic [4:0]      exmem_rd, memwb_rd;
  logic            exmem_reg_write, memwb_reg_write;
  logic [XLEN-1:0] exmem_result, memwb_result;
  logic [XLEN-1:0] a, b, store_data;
  logic [3:0]      ALUop;
  logic [4:0]      ex_rd;
  logic            ex_reg_write, ex_mem_read, ex_valid, load_use_stall;

  int checks   = 0;
  int failures = 0;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_ALUop(id_ALUop), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_valid(id_valid),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .a(a), .b(b), .store_data(store_data), .ALUop(ALUop), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_valid(ex_valid),
    .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_ALUop = 0;
    id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_valid = 0;
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed forwarding vectors: capture an entry, then present producers.
  typedef struct {
    string       name;
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic        src;
    logic [4:0]  exrd;  logic exw; logic [31:0] exres;
    logic [4:0]  wbrd;  logic wbw; logic [31:0] wbres;
    logic [31:0] ea, eb, esd;
  } vec_t;

  vec_t vec[8];

  // Behavioural model of the held entry.
  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [3:0]  op;
    logic        src, rw, mr, vld;
  } ent_t;

  ent_t m;

  function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] regv);
    if (r == 0) return regv;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_result;
    return regv;
  endfunction

  initial begin
    clear_inputs();
    rst_n = 1'b0;

    // ---- reset state ----
    #2;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_store", store_data, 0);
    chk("rst_valid", {31'd0, ex_valid}, 0);
    chk("rst_lus", {31'd0, load_use_stall}, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // ---- directed table ----
    vec[0] = '{"capture",   5'd3, 5'd0, 32'h10,  32'h0,   32'h5,  1'b1,
               5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  32'h10, 32'h5,  32'h0};
    vec[1] = '{"prio_both", 5'd4, 5'd0, 32'h1,   32'h2,   32'h0,  1'b0,
               5'd4, 1'b1, 32'hAA, 5'd4, 1'b1, 32'hBB, 32'hAA, 32'h2,  32'h2};
    vec[2] = '{"prio_wb",   5'd4, 5'd0, 32'h1,   32'h2,   32'h0,  1'b0,
               5'd4, 1'b0, 32'hAA, 5'd4, 1'b1, 32'hBB, 32'hBB, 32'h2,  32'h2};
    vec[3] = '{"zero_reg",  5'd0, 5'd0, 32'h0,   32'h0,   32'h0,  1'b0,
               5'd0, 1'b1, 32'hFF, 5'd0, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0};
    vec[4] = '{"split_fwd", 5'd1, 5'd2, 32'h100, 32'h200, 32'h0,  1'b0,
               5'd2, 1'b1, 32'hCC, 5'd1, 1'b1, 32'hDD, 32'hDD, 32'hCC, 32'hCC};
    vec[5] = '{"imm_sel",   5'd5, 5'd2, 32'h55,  32'h200, 32'h77, 1'b1,
               5'd2, 1'b1, 32'hCC, 5'd0, 1'b0, 32'h0,  32'h55, 32'h77, 32'hCC};
    vec[6] = '{"no_match",  5'd6, 5'd9, 32'h66,  32'h99,  32'h0,  1'b0,
               5'd7, 1'b1, 32'hEE, 5'd8, 1'b1, 32'h11, 32'h66, 32'h99, 32'h99};
    vec[7] = '{"wb_zero",   5'd0, 5'd0, 32'h12,  32'h13,  32'h0,  1'b0,
               5'd0, 1'b1, 32'h33, 5'd0, 1'b1, 32'h34, 32'h12, 32'h13, 32'h13};

    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      id_rs1 = vec[i].rs1; id_rs2 = vec[i].rs2;
      id_rs1_data = vec[i].d1; id_rs2_data = vec[i].d2; id_imm = vec[i].imm;
      id_alu_src = vec[i].src; id_valid = 1; id_rd = 5'd10;
      tick();
      exmem_rd = vec[i].exrd; exmem_reg_write = vec[i].exw; exmem_result = vec[i].exres;
      memwb_rd = vec[i].wbrd; memwb_reg_write = vec[i].wbw; memwb_result = vec[i].wbres;
      #1;
      chk({vec[i].name, "_a"}, a, vec[i].ea);
      chk({vec[i].name, "_b"}, b, vec[i].eb);
      chk({vec[i].name, "_store"}, store_data, vec[i].esd);
      chk({vec[i].name, "_valid"}, {31'd0, ex_valid}, 1);
    end

    // ---- load-use: detect, hold under stall, pick up MEM/WB result ----
    clear_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5'd7;
    id_rs2 = 5'd7; id_rs2_data = 32'h11;
    tick();
    id_rs1 = 5'd0; id_rs2 = 5'd7; id_rd = 5'd8; id_mem_read = 0; id_rs2_data = 32'h99;
    #1;
    chk("lu_detect", {31'd0, load_use_stall}, 1);
    id_valid = 0;
    #1;
    chk("lu_idle", {31'd0, load_use_stall}, 0);
    id_valid = 1;
    stall = 1;
    tick();
    chk("lu_hold_rd", {27'd0, ex_rd}, 7);
    chk("lu_hold_mr", {31'd0, ex_mem_read}, 1);
    chk("lu_store_pre", store_data, 32'h11);
    memwb_rd = 5'd7; memwb_reg_write = 1; memwb_result = 32'h42;
    #1;
    chk("lu_store_fwd", store_data, 32'h42);

    // ---- flush beats stall ----
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_ALUop = 4'd5; id_rd = 5'd3;
    tick();
    chk("fl_pre_op", {28'd0, ALUop}, 5);
    stall = 1; flush = 1;
    tick();
    chk("fl_valid", {31'd0, ex_valid}, 0);
    chk("fl_rw", {31'd0, ex_reg_write}, 0);
    chk("fl_op", {28'd0, ALUop}, 0);

    // ---- async reset mid-stall, between edges ----
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_mem_read = 1; id_rd = 5'd4; id_ALUop = 4'd9;
    id_rs1 = 5'd2; id_rs1_data = 32'hDEAD; id_rs2 = 5'd4; id_rs2_data = 32'hBEEF;
    tick();
    chk("ar_pre_valid", {31'd0, ex_valid}, 1);
    stall = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, ex_valid}, 0);
    chk("ar_a", a, 0);
    chk("ar_store", store_data, 0);
    chk("ar_ctl", {24'd0, ALUop, ex_reg_write, ex_mem_read, 2'b00}, 0);
    chk("ar_lus", {31'd0, load_use_stall}, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("ar_discard", {31'd0, ex_valid}, 0);

    // ---- randomized traffic against the model ----
    m = '{default: '0};
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_ALUop = 4'($urandom); id_alu_src = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
      id_valid = ($urandom_range(0, 4) != 0);
      exmem_rd = 5'($urandom_range(0, 3)); exmem_reg_write = 1'($urandom);
      exmem_result = $urandom;
      memwb_rd = 5'($urandom_range(0, 3)); memwb_reg_write = 1'($urandom);
      memwb_result = $urandom;
      #1;
      chk("rnd_a", a, model_fwd(m.rs1, m.d1));
      chk("rnd_b", b, m.src ? m.imm : model_fwd(m.rs2, m.d2));
      chk("rnd_store", store_data, model_fwd(m.rs2, m.d2));
      chk("rnd_ctl", {20'd0, ALUop, ex_rd, ex_reg_write, ex_mem_read, ex_valid},
          {20'd0, m.op, m.rd, m.rw, m.mr, m.vld});
      chk("rnd_lus", {31'd0, load_use_stall},
          {31'd0, m.vld && m.mr && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2) && id_valid});
      @(posedge clk);
      if (flush) begin
        m.vld = 0; m.rw = 0; m.mr = 0; m.op = 0;
      end else if (!stall) begin
        m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
        m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm;
        m.op = id_ALUop; m.src = id_alu_src; m.vld = id_valid;
        m.rw = id_valid && id_reg_write;
        m.mr = id_valid && id_mem_read;
      end
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
